// File: rtl/handshake_pkg.sv
// Shared types and sizing helpers for the valid/ready FIFO family.
package handshake_pkg;

    typedef enum logic {
        FIFO_REGISTERED = 1'b0,
        FIFO_BYPASS     = 1'b1
    } fifo_mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module handshake_fifo_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO with registered or zero-latency bypass output; ready never
// depends on dn_ready_in.
module handshake_fifo
    import handshake_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter fifo_mode_e  MODE     = FIFO_REGISTERED,
    parameter int unsigned AF_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       up_valid_in,
    output logic                       up_ready_out,
    output logic [WIDTH-1:0]           data_out,
    output logic                       dn_valid_out,
    input  logic                       dn_ready_in,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned AW = PW - 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic [CW-1:0]    w_count;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_wr_en;
    logic             w_rd_adv;
    logic [WIDTH-1:0] w_rdata;

    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_count = CW'(r_wr_ptr - r_rd_ptr);

    assign count        = rst ? '0 : w_count;
    assign almost_full  = !rst && (w_count >= CW'(AF_LEVEL));
    assign up_ready_out = !rst && !w_full;

    assign w_push = up_valid_in && up_ready_out;
    assign w_pop  = dn_valid_out && dn_ready_in;

    // Bypass mode presents data_in directly while empty; a same-cycle pop then skips storage.
    if (MODE == FIFO_BYPASS) begin : g_bypass
        assign dn_valid_out = !rst && (!w_empty || up_valid_in);
        assign data_out     = w_empty ? data_in : w_rdata;
        assign w_bypass     = w_empty && w_push && w_pop;
    end else begin : g_registered
        assign dn_valid_out = !rst && !w_empty;
        assign data_out     = w_rdata;
        assign w_bypass     = 1'b0;
    end

    assign w_wr_en  = w_push && !w_bypass;
    assign w_rd_adv = w_pop && !w_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    handshake_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr (r_wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (r_rd_ptr[AW-1:0]),
        .rdata (w_rdata)
    );

endmodule

// File: tb/tb_handshake_fifo.sv
// Directed bench for handshake_fifo: registered instance plus bypass instance.
module tb_handshake_fifo;
    import handshake_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] d0_din, d0_dout;
    logic        d0_valid, d0_up_ready, d0_dn_valid, d0_ready, d0_af;
    logic [2:0]  d0_count;

    logic [31:0] d1_din, d1_dout;
    logic        d1_valid, d1_up_ready, d1_dn_valid, d1_ready, d1_af;
    logic [2:0]  d1_count;

    int          n_chk  = 0;
    int          n_pass = 0;

    logic [31:0] q[$];
    logic        hold;
    logic        cv;
    logic [31:0] cd;
    logic        cr;

    always #5 clk = ~clk;

    handshake_fifo #(
        .WIDTH(32), .DEPTH(4), .MODE(FIFO_REGISTERED), .AF_LEVEL(3)
    ) u_dut0 (
        .clk(clk), .rst(rst), .data_in(d0_din), .up_valid_in(d0_valid),
        .up_ready_out(d0_up_ready), .data_out(d0_dout), .dn_valid_out(d0_dn_valid),
        .dn_ready_in(d0_ready), .count(d0_count), .almost_full(d0_af)
    );

    handshake_fifo #(
        .WIDTH(32), .DEPTH(4), .MODE(FIFO_BYPASS), .AF_LEVEL(3)
    ) u_dut1 (
        .clk(clk), .rst(rst), .data_in(d1_din), .up_valid_in(d1_valid),
        .up_ready_out(d1_up_ready), .data_out(d1_dout), .dn_valid_out(d1_dn_valid),
        .dn_ready_in(d1_ready), .count(d1_count), .almost_full(d1_af)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One registered-instance cycle checked against the queue model.
    task automatic step_model(input logic v, input logic [31:0] d, input logic r);
        logic push, pop;
        d0_valid = v;
        d0_din   = d;
        d0_ready = r;
        #1;
        chk("sb_count", 32'(d0_count), 32'(q.size()));
        chk("sb_valid", 32'(d0_dn_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("sb_data", d0_dout, q[0]);
        push = v && (q.size() < 4);
        pop  = r && (q.size() != 0);
        tick();
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        hold = v && !push;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        d0_din = '0; d0_valid = 1'b0; d0_ready = 1'b0;
        d1_din = '0; d1_valid = 1'b0; d1_ready = 1'b0;
        hold = 1'b0;

        // Reset / idle
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_up_ready", 32'(d0_up_ready), 32'd0);
            chk("rst_dn_valid", 32'(d0_dn_valid), 32'd0);
            chk("rst_count",    32'(d0_count),    32'd0);
            tick();
        end
        chk("rst_af", 32'(d0_af), 32'd0);
        chk("rst_b_up_ready", 32'(d1_up_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_up_ready", 32'(d0_up_ready), 32'd1);
        chk("post_rst_dn_valid", 32'(d0_dn_valid), 32'd0);
        tick();

        // Streaming in registered mode
        d0_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d0_valid = 1'b1;
            d0_din   = 32'(i);
            #1;
            if (i > 0) begin
                chk("stream_valid", 32'(d0_dn_valid), 32'd1);
                chk("stream_data",  d0_dout, 32'(i - 1));
                chk("stream_count", 32'(d0_count), 32'd1);
            end else begin
                chk("stream_first_valid", 32'(d0_dn_valid), 32'd0);
            end
            tick();
        end
        d0_valid = 1'b0;
        #1;
        chk("stream_last_data", d0_dout, 32'd15);
        chk("stream_last_count", 32'(d0_count), 32'd1);
        tick();
        chk("stream_empty_count", 32'(d0_count), 32'd0);
        chk("stream_empty_valid", 32'(d0_dn_valid), 32'd0);

        // Fill with back-pressure
        d0_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            d0_valid = 1'b1;
            d0_din   = 32'(16 + k);
            #1;
            chk("fill_count",    32'(d0_count),    32'(k));
            chk("fill_af",       32'(d0_af),       32'(k >= 3));
            chk("fill_up_ready", 32'(d0_up_ready), 32'(k < 4));
            tick();
        end
        chk("full_hold_count", 32'(d0_count), 32'd4);

        // Full with simultaneous pop: pop only, then push+pop
        d0_ready = 1'b1;
        #1;
        chk("full_up_ready", 32'(d0_up_ready), 32'd0);
        chk("full_head", d0_dout, 32'd16);
        tick();
        chk("fp_count_pop", 32'(d0_count), 32'd3);
        chk("fp_up_ready",  32'(d0_up_ready), 32'd1);
        chk("fp_head17",    d0_dout, 32'd17);
        tick();
        chk("fp_count_both", 32'(d0_count), 32'd3);
        d0_valid = 1'b0;
        for (int k = 18; k <= 20; k++) begin
            #1;
            chk("drain_valid", 32'(d0_dn_valid), 32'd1);
            chk("drain_data",  d0_dout, 32'(k));
            tick();
        end
        chk("drain_count", 32'(d0_count), 32'd0);

        // Bypass mode: same-cycle pass-through while empty
        d1_ready = 1'b1;
        d1_valid = 1'b1;
        d1_din   = 32'hDEADBEEF;
        #1;
        chk("byp_data",  d1_dout, 32'hDEADBEEF);
        chk("byp_valid", 32'(d1_dn_valid), 32'd1);
        chk("byp_count", 32'(d1_count), 32'd0);
        tick();
        chk("byp_count_after", 32'(d1_count), 32'd0);
        d1_valid = 1'b1;
        d1_din   = 32'h0000_00A1;
        d1_ready = 1'b0;
        #1;
        chk("byp_bp_data", d1_dout, 32'h0000_00A1);
        tick();
        chk("byp_bp_count", 32'(d1_count), 32'd1);
        d1_din   = 32'h0000_00B2;
        d1_ready = 1'b1;
        #1;
        chk("byp_stored_head", d1_dout, 32'h0000_00A1);
        tick();
        chk("byp_both_count", 32'(d1_count), 32'd1);
        d1_valid = 1'b0;
        #1;
        chk("byp_second", d1_dout, 32'h0000_00B2);
        tick();
        chk("byp_drained", 32'(d1_count), 32'd0);
        d1_ready = 1'b0;

        // Random run with wrapping pointers, then drain
        q.delete();
        hold = 1'b0;
        cv = 1'b0;
        cd = '0;
        for (int n = 0; n < 9; n++) begin
            if (!hold) begin
                cv = 1'($urandom_range(0, 1));
                cd = $urandom;
            end
            cr = 1'($urandom_range(0, 1));
            step_model(cv, cd, cr);
        end
        for (int n = 0; n < 10; n++) begin
            if (!hold && q.size() == 0) break;
            step_model(hold ? cv : 1'b0, cd, 1'b1);
        end

        // Mid-run reset with two stored words
        step_model(1'b1, 32'hA5A5_0001, 1'b0);
        step_model(1'b1, 32'hA5A5_0002, 1'b0);
        d0_valid = 1'b0;
        #1;
        chk("pre_rst_count", 32'(d0_count), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_count",    32'(d0_count),    32'd0);
        chk("mid_rst_up_ready", 32'(d0_up_ready), 32'd0);
        chk("mid_rst_dn_valid", 32'(d0_dn_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("after_rst_count", 32'(d0_count),    32'd0);
        chk("after_rst_valid", 32'(d0_dn_valid), 32'd0);
        chk("after_rst_ready", 32'(d0_up_ready), 32'd1);
        q.delete();
        hold = 1'b0;
        step_model(1'b1, 32'h0000_C0DE, 1'b1);
        step_model(1'b0, 32'h0, 1'b1);
        step_model(1'b0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
